// File: rtl/uart_bridge_pkg.sv
// Shared types and byte constants for the UART register bridge.
// Optional feature macro: UART_BRIDGE_CHECKSUM_EN (adds a trailing XOR byte per packet).
package uart_bridge_pkg;

  // Bridge FSM states. GET_CSUM is only reachable with the checksum build.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_ADDR  = 3'd1,
    GET_DATA  = 3'd2,
    GET_CSUM  = 3'd3,
    EXEC      = 3'd4,
    READ_WAIT = 3'd5,
    SEND_RESP = 3'd6
  } state_t;

  // Command bytes received from the host.
  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;

  // Response bytes returned to the host.
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_BAD  = 8'h3F;
  localparam logic [7:0] RSP_CSUM = 8'h45;

  // True for the two command bytes that open a packet.
  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WR) || (b == CMD_RD);
  endfunction

endpackage

// File: rtl/uart_bridge_timer.sv
// Inter-byte timeout counter for the UART register bridge.
// Counts enabled cycles since the last clear and saturates at TIMEOUT_CYCLES;
// expire is asserted while enabled and saturated.
module uart_bridge_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up while enabled, holding at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_reg_bridge.sv
// UART-to-register bridge: parses write (0x57,addr,data) and read (0x52,addr)
// packets from an RX FIFO, drives a simple register port and answers on a TX FIFO.
// Optional feature macro: UART_BRIDGE_CHECKSUM_EN -- each packet carries a trailing
// byte equal to the XOR of the preceding bytes; a mismatch is answered with 0x45.
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       rx_rd,
  output logic [7:0] tx_data,
  output logic       tx_wrt,
  input  logic       tx_full,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       err_timeout
);

  state_t     state_q, state_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       err_timeout_q, err_timeout_d;
  // Set in the cycle after a pop so the FIFO head has time to advance; it is
  // held high through reset so no pop can be issued while reset is asserted.
  logic       pop_block_q, pop_block_d;
  logic       pop;
  logic       can_pop;
  logic       timer_en;
  logic       timer_expire;
`ifdef UART_BRIDGE_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  assign can_pop  = !rx_empty && !pop_block_q;
  assign timer_en = (state_q == GET_ADDR) || (state_q == GET_DATA) || (state_q == GET_CSUM);

  uart_bridge_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (pop),
    .en    (timer_en),
    .expire(timer_expire)
  );

  // Packet-parsing FSM: next state, byte pops and latched packet fields.
  always_comb begin
    state_d       = state_q;
    is_wr_d       = is_wr_q;
    reg_addr_d    = reg_addr_q;
    reg_wdata_d   = reg_wdata_q;
    tx_data_d     = tx_data_q;
    err_timeout_d = 1'b0;
    pop           = 1'b0;
`ifdef UART_BRIDGE_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (can_pop) begin
          pop = 1'b1;
          if (is_cmd(rx_data)) begin
            is_wr_d = (rx_data == CMD_WR);
            state_d = GET_ADDR;
`ifdef UART_BRIDGE_CHECKSUM_EN
            csum_d  = rx_data;
`endif
          end else begin
            tx_data_d = RSP_BAD;
            state_d   = SEND_RESP;
          end
        end
      end
      GET_ADDR: begin
        if (can_pop) begin
          pop        = 1'b1;
          reg_addr_d = rx_data;
`ifdef UART_BRIDGE_CHECKSUM_EN
          csum_d     = csum_q ^ rx_data;
          state_d    = is_wr_q ? GET_DATA : GET_CSUM;
`else
          state_d    = is_wr_q ? GET_DATA : EXEC;
`endif
        end else if (timer_expire) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end
      GET_DATA: begin
        if (can_pop) begin
          pop         = 1'b1;
          reg_wdata_d = rx_data;
`ifdef UART_BRIDGE_CHECKSUM_EN
          csum_d      = csum_q ^ rx_data;
          state_d     = GET_CSUM;
`else
          state_d     = EXEC;
`endif
        end else if (timer_expire) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end
      GET_CSUM: begin
`ifdef UART_BRIDGE_CHECKSUM_EN
        if (can_pop) begin
          pop = 1'b1;
          if (rx_data == csum_q) begin
            state_d = EXEC;
          end else begin
            tx_data_d = RSP_CSUM;
            state_d   = SEND_RESP;
          end
        end else if (timer_expire) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end
`else
        // Unreachable without the checksum build; recover to IDLE.
        state_d = IDLE;
`endif
      end
      EXEC: begin
        if (is_wr_q) begin
          tx_data_d = RSP_OK;
          state_d   = SEND_RESP;
        end else begin
          state_d   = READ_WAIT;
        end
      end
      READ_WAIT: begin
        // reg_rdata is valid now, one cycle after the reg_re issued in EXEC.
        tx_data_d = reg_rdata;
        state_d   = SEND_RESP;
      end
      SEND_RESP: begin
        if (!tx_full) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pop_block_d = pop;
  end

  // State and packet-field registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      is_wr_q       <= 1'b0;
      reg_addr_q    <= 8'h00;
      reg_wdata_q   <= 8'h00;
      tx_data_q     <= 8'h00;
      err_timeout_q <= 1'b0;
      pop_block_q   <= 1'b1;
`ifdef UART_BRIDGE_CHECKSUM_EN
      csum_q        <= 8'h00;
`endif
    end else begin
      state_q       <= state_d;
      is_wr_q       <= is_wr_d;
      reg_addr_q    <= reg_addr_d;
      reg_wdata_q   <= reg_wdata_d;
      tx_data_q     <= tx_data_d;
      err_timeout_q <= err_timeout_d;
      pop_block_q   <= pop_block_d;
`ifdef UART_BRIDGE_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  // Strobes are decoded from the registered state so each lasts exactly one
  // cycle; rx_rd and tx_wrt also honour the FIFO flags of the current cycle.
  assign rx_rd       = pop;
  assign reg_we      = (state_q == EXEC) && is_wr_q;
  assign reg_re      = (state_q == EXEC) && !is_wr_q;
  assign tx_wrt      = (state_q == SEND_RESP) && !tx_full;
  assign tx_data     = tx_data_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Self-checking bench for uart_reg_bridge (TIMEOUT_CYCLES = 20).
// Build with +define+UART_BRIDGE_CHECKSUM_EN to exercise the checksum variant.
module tb_uart_reg_bridge;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_rd;
  logic [7:0] tx_data;
  logic       tx_wrt;
  logic       tx_full;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       err_timeout;

  always #5 clk = ~clk;

  uart_reg_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_empty   (rx_empty),
    .rx_rd      (rx_rd),
    .tx_data    (tx_data),
    .tx_wrt     (tx_wrt),
    .tx_full    (tx_full),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata),
    .err_timeout(err_timeout)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_log[$];
  logic [15:0] wr_log[$];
  logic [7:0]  rd_log[$];
  logic [7:0]  mem[256];
  logic [7:0]  ref_mem[256];
  logic [7:0]  seed;
  logic [7:0]  pkt[$];
  int err_cnt = 0, b2b_cnt = 0, txfull_viol = 0;
  int cyc = 0, last_rd_cyc = 0, last_tx_cyc = 0;
  logic rx_rd_prev = 1'b0;

  // Expected results of the packet in pkt[]
  logic [7:0] exp_resp, exp_addr, exp_data;
  bit         exp_wr, exp_rd;

  // RX FIFO model: first-word-fall-through, popped by rx_rd.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_rd && rx_q.size() != 0) void'(rx_q.pop_front());
    rx_empty <= (rx_q.size() == 0);
    rx_data  <= (rx_q.size() == 0) ? 8'h00 : rx_q[0];
  end

  // Register slave: read data valid only the cycle after reg_re, junk otherwise.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 29) ^ seed;
    end else if (reg_we) begin
      mem[reg_addr] <= reg_wdata;
    end
    reg_rdata <= reg_re ? mem[reg_addr] : 8'($urandom);
  end

  // Monitor on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (reg_we) wr_log.push_back({reg_addr, reg_wdata});
      if (reg_re) rd_log.push_back(reg_addr);
      if (tx_wrt) begin tx_log.push_back(tx_data); last_tx_cyc = cyc; end
      if (tx_wrt && tx_full) txfull_viol++;
      if (err_timeout) err_cnt++;
      if (rx_rd) begin
        if (rx_rd_prev) b2b_cnt++;
        last_rd_cyc = cyc;
      end
      rx_rd_prev = rx_rd;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Append the packet checksum when the checksum build is active.
  task automatic seal_pkt();
`ifdef UART_BRIDGE_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (pkt[i]) x ^= pkt[i];
    pkt.push_back(x);
`endif
  endtask

  // Reference model: interpret pkt[] from the protocol rules, update ref_mem.
  task automatic model_pkt();
    exp_wr = 0;
    exp_rd = 0;
    exp_addr = 8'h00;
    exp_data = 8'h00;
    if (pkt[0] != 8'h57 && pkt[0] != 8'h52) begin
      exp_resp = 8'h3F;
      return;
    end
`ifdef UART_BRIDGE_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < pkt.size() - 1; i++) x ^= pkt[i];
      if (x != pkt[pkt.size() - 1]) begin
        exp_resp = 8'h45;
        return;
      end
    end
`endif
    exp_addr = pkt[1];
    if (pkt[0] == 8'h57) begin
      exp_data = pkt[2];
      exp_wr   = 1;
      ref_mem[exp_addr] = exp_data;
      exp_resp = 8'h4B;
    end else begin
      exp_rd   = 1;
      exp_resp = ref_mem[exp_addr];
    end
  endtask

  // Send pkt[] with `gap` cycles between bytes and check the whole transaction.
  task automatic do_pkt(input string tag, input int gap);
    int t0, w0, r0, e0;
    t0 = tx_log.size(); w0 = wr_log.size(); r0 = rd_log.size(); e0 = err_cnt;
    model_pkt();
    foreach (pkt[i]) begin
      rx_q.push_back(pkt[i]);
      if (gap > 0) tick(gap);
    end
    for (int i = 0; i < 400 && tx_log.size() == t0; i++) tick(1);
    tick(3);
    check({tag, ".tx_count"}, tx_log.size() - t0, 1);
    if (tx_log.size() > t0) check({tag, ".tx_data"}, tx_log[t0], exp_resp);
    check({tag, ".we_count"}, wr_log.size() - w0, exp_wr ? 1 : 0);
    if (exp_wr && wr_log.size() > w0) check({tag, ".we_addr_data"}, wr_log[w0], {exp_addr, exp_data});
    check({tag, ".re_count"}, rd_log.size() - r0, exp_rd ? 1 : 0);
    if (exp_rd && rd_log.size() > r0) check({tag, ".re_addr"}, rd_log[r0], exp_addr);
    check({tag, ".no_timeout"}, err_cnt - e0, 0);
    $display("[TB] %-14s bytes=%0d wr=%0d rd=%0d addr=0x%02h resp=0x%02h", tag, pkt.size(),
             exp_wr, exp_rd, exp_addr, exp_resp);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, w0, r0, e0;
    seed    = 8'($urandom);
    reset   = 1'b1;
    tx_full = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 29) ^ seed;

    // Reset state, with a byte sitting in the RX FIFO.
    tick(2);
    rx_q.push_back(8'h57);
    tick(3);
    check("reset.rx_rd", rx_rd, 0);
    check("reset.tx_wrt", tx_wrt, 0);
    check("reset.reg_we", reg_we, 0);
    check("reset.reg_re", reg_re, 0);
    check("reset.err_timeout", err_timeout, 0);
    check("reset.tx_data", tx_data, 0);
    check("reset.reg_addr", reg_addr, 0);
    check("reset.reg_wdata", reg_wdata, 0);
    rx_q.delete();
    tick(2);
    reset = 1'b0;
    tick(2);

    // Basic write and write-response latency.
    pkt = {8'h57, 8'h10, 8'hA5}; seal_pkt();
    do_pkt("write_10_A5", 0);
    check("write.latency", last_tx_cyc - last_rd_cyc, 2);

    // Read back a known value and read-response latency.
    pkt = {8'h57, 8'h22, 8'h3C}; seal_pkt();
    do_pkt("write_22_3C", 0);
    pkt = {8'h52, 8'h22}; seal_pkt();
    do_pkt("read_22", 0);
    check("read.latency", last_tx_cyc - last_rd_cyc, 3);

    // Unknown command byte, then normal service resumes.
    pkt = {8'h00};
    do_pkt("bad_00", 0);
    pkt = {8'h52, 8'h10}; seal_pkt();
    do_pkt("read_after_bad", 0);

    // Inter-byte gaps shorter than the timeout are tolerated.
    pkt = {8'h57, 8'h77, 8'h5A}; seal_pkt();
    do_pkt("write_gap15", 15);

    // Timeout: command byte followed by silence.
    t0 = tx_log.size(); w0 = wr_log.size(); r0 = rd_log.size(); e0 = err_cnt;
    rx_q.push_back(8'h57);
    tick(15);
    check("timeout.not_early", err_cnt - e0, 0);
    tick(30);
    check("timeout.err_pulses", err_cnt - e0, 1);
    check("timeout.no_we", wr_log.size() - w0, 0);
    check("timeout.no_re", rd_log.size() - r0, 0);
    check("timeout.no_tx", tx_log.size() - t0, 0);
    $display("[TB] %-14s err_pulses=%0d", "timeout", err_cnt - e0);
    pkt = {8'h52, 8'h77}; seal_pkt();
    do_pkt("read_after_to", 0);

    // Back-pressure: tx_full held high for 50 cycles during a response.
    t0 = tx_log.size();
    tx_full = 1'b1;
    pkt = {8'h52, 8'h10}; seal_pkt();
    model_pkt();
    foreach (pkt[i]) rx_q.push_back(pkt[i]);
    tick(50);
    check("txfull.held", tx_log.size() - t0, 0);
    tx_full = 1'b0;
    tick(10);
    check("txfull.one_write", tx_log.size() - t0, 1);
    if (tx_log.size() > t0) check("txfull.data", tx_log[t0], exp_resp);
    $display("[TB] %-14s resp=0x%02h", "txfull_read", exp_resp);

    // Reset mid-packet discards the partial packet.
    w0 = wr_log.size();
    rx_q.push_back(8'h57); rx_q.push_back(8'h33);
    tick(8);
    reset = 1'b1;
    tick(1);
    check("midreset.reg_addr", reg_addr, 0);
    check("midreset.rx_rd", rx_rd, 0);
    rx_q.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 29) ^ seed;
    tick(2);
    reset = 1'b0;
    tick(2);
    check("midreset.no_we", wr_log.size() - w0, 0);
    pkt = {8'h52, 8'h33}; seal_pkt();
    do_pkt("read_after_rst", 0);

`ifdef UART_BRIDGE_CHECKSUM_EN
    pkt = {8'h57, 8'h01, 8'h02, 8'h54};
    do_pkt("csum_good", 0);
    pkt = {8'h57, 8'h01, 8'h02, 8'h00};
    do_pkt("csum_bad", 0);
`endif

    // Randomized mix of writes, reads and junk bytes.
    for (int n = 0; n < 24; n++) begin
      int kind;
      logic [7:0] a, d;
      kind = $urandom_range(0, 2);
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      if (kind == 0) begin
        pkt = {8'h57, a, d}; seal_pkt();
      end else if (kind == 1) begin
        pkt = {8'h52, a}; seal_pkt();
      end else begin
        if (d == 8'h57 || d == 8'h52) d = 8'h00;
        pkt = {d};
      end
      do_pkt($sformatf("rand_%0d", n), $urandom_range(0, 3));
    end

    check("global.no_back_to_back_rx_rd", b2b_cnt, 0);
    check("global.no_tx_wrt_when_full", txfull_viol, 0);
    check("global.rx_fifo_drained", rx_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
